// File: rtl/yutorina_spm_responder.sv
// Scratchpad memory beside the fetch stage: combinational instruction read port,
// request/acknowledge data port, and a post-reset clear sequence that fills memory with NOP_WORD.
module yutorina_spm_responder #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] inst_read_address,
    output logic [DATA_WIDTH-1:0] inst_read_data,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] data_write_data,
    output logic                  data_ack,
    output logic [DATA_WIDTH-1:0] data_read_data,
    output logic                  ready
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   clear_count, clear_count_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    ack_next;
    logic                    rd_load;

    // Single write port shared by the clear sequence and the data port.
    always_comb begin
        state_next       = state;
        clear_count_next = clear_count;
        mem_we           = 1'b0;
        mem_waddr        = clear_count;
        mem_wdata        = NOP_WORD;
        ack_next         = 1'b0;
        rd_load          = 1'b0;
        ready            = 1'b0;
        inst_read_data   = NOP_WORD;
        case (state)
            ST_CLEAR: begin
                mem_we           = 1'b1;
                clear_count_next = clear_count + ADDR_WIDTH'(1);
                if (&clear_count) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                ready          = 1'b1;
                inst_read_data = mem[inst_read_address];
                if (data_req) begin
                    ack_next = 1'b1;
                    if (data_we) begin
                        mem_we    = 1'b1;
                        mem_waddr = data_address;
                        mem_wdata = data_write_data;
                    end else begin
                        rd_load = 1'b1;
                    end
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_CLEAR;
            clear_count    <= '0;
            data_ack       <= 1'b0;
            data_read_data <= '0;
        end else begin
            state       <= state_next;
            clear_count <= clear_count_next;
            data_ack    <= ack_next;
            if (rd_load) begin
                data_read_data <= mem[data_address];
            end
        end
    end

    // A request in flight on a reset edge is dropped, including its write.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_yutorina_spm_responder.sv
// Self-checking bench for yutorina_spm_responder with a small array-based memory model.
module tb_yutorina_spm_responder;
    localparam int              AW    = 4;
    localparam int              DW    = 32;
    localparam int              DEPTH = 1 << AW;
    localparam logic [DW-1:0]   NOP   = 32'h0;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] inst_read_address;
    logic [DW-1:0] inst_read_data;
    logic          data_req;
    logic          data_we;
    logic [AW-1:0] data_address;
    logic [DW-1:0] data_write_data;
    logic          data_ack;
    logic [DW-1:0] data_read_data;
    logic          ready;

    yutorina_spm_responder #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NOP_WORD  (NOP)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .inst_read_address(inst_read_address),
        .inst_read_data   (inst_read_data),
        .data_req         (data_req),
        .data_we          (data_we),
        .data_address     (data_address),
        .data_write_data  (data_write_data),
        .data_ack         (data_ack),
        .data_read_data   (data_read_data),
        .ready            (ready)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: memory reads as all-NOP once clearing completes; requests are honoured only when ready.
    logic [DW-1:0] mdl_mem [DEPTH];
    int            mdl_cyc   = 0;
    bit            mdl_ready = 1'b0;
    bit            exp_ack   = 1'b0;
    logic [DW-1:0] exp_rdata = '0;

    task automatic tick();
        @(posedge clock);
        if (reset) begin
            mdl_cyc   = 0;
            mdl_ready = 1'b0;
            exp_ack   = 1'b0;
            exp_rdata = '0;
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = NOP;
        end else begin
            exp_ack = mdl_ready && data_req;
            if (mdl_ready && data_req) begin
                if (data_we) mdl_mem[data_address] = data_write_data;
                else         exp_rdata = mdl_mem[data_address];
            end
            mdl_cyc++;
            if (mdl_cyc >= DEPTH) mdl_ready = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready); end
        tests++; if (data_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b expected 0", data_ack); end
        tests++; if (data_read_data !== '0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", data_read_data); end
        reset = 1'b0;
    endtask

    // Requester holds a write through the whole clear; only the first READY cycle's write may land.
    task automatic test_clear_with_held_req();
        inst_read_address = 4'd5;
        data_req = 1'b1;
        data_we  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            data_address    = AW'(i);
            data_write_data = 32'hBAD0_0000 | i;
            #1;
            tests++; if (inst_read_data !== NOP) begin fails++; $display("FAIL clear_inst c%0d: got %h expected %h", i, inst_read_data, NOP); end
            tests++; if (data_ack !== 1'b0) begin fails++; $display("FAIL clear_ack c%0d: got %b expected 0", i, data_ack); end
            tick();
            tests++; if (ready !== (i == DEPTH - 1)) begin fails++; $display("FAIL clear_ready c%0d: got %b expected %b", i, ready, i == DEPTH - 1); end
        end
        data_address    = 4'd9;
        data_write_data = 32'h00C0_FFEE;
        tick();
        tests++; if (data_ack !== 1'b1) begin fails++; $display("FAIL held_ack: got %b expected 1", data_ack); end
        data_req = 1'b0;
        tick();
        tests++; if (data_ack !== 1'b0) begin fails++; $display("FAIL held_ack_pulse: got %b expected 0", data_ack); end
        for (int a = 0; a < DEPTH; a++) begin
            inst_read_address = AW'(a);
            #1;
            tests++;
            if (inst_read_data !== ((a == 9) ? 32'h00C0_FFEE : NOP)) begin
                fails++; $display("FAIL post_clear_mem a%0d: got %h expected %h", a, inst_read_data, (a == 9) ? 32'h00C0_FFEE : NOP);
            end
        end
    endtask

    task automatic test_write_then_fetch();
        data_req = 1'b1; data_we = 1'b1; data_address = 4'd3; data_write_data = 32'hDEAD_BEEF;
        tick();
        data_req = 1'b0;
        tests++; if (data_ack !== 1'b1) begin fails++; $display("FAIL wr_ack: got %b expected 1", data_ack); end
        inst_read_address = 4'd3;
        #1;
        tests++; if (inst_read_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_fetch: got %h expected deadbeef", inst_read_data); end
        tick();
        tests++; if (data_ack !== 1'b0) begin fails++; $display("FAIL wr_ack_pulse: got %b expected 0", data_ack); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] va, vb;
        logic [DW-1:0] wd [4];
        logic [AW-1:0] ad [4];
        logic          we [4];
        va = $urandom(); vb = $urandom();
        wd[0] = va; wd[1] = vb; wd[2] = '0; wd[3] = '0;
        ad[0] = 4'd1; ad[1] = 4'd2; ad[2] = 4'd1; ad[3] = 4'd2;
        we[0] = 1'b1; we[1] = 1'b1; we[2] = 1'b0; we[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            data_req = 1'b1; data_we = we[k]; data_address = ad[k]; data_write_data = wd[k];
            tick();
            tests++; if (data_ack !== 1'b1) begin fails++; $display("FAIL b2b_ack k%0d: got %b expected 1", k, data_ack); end
        end
        tests++; if (data_read_data !== vb) begin fails++; $display("FAIL b2b_rd2: got %h expected %h", data_read_data, vb); end
        data_req = 1'b0;
        tick();
        tests++; if (data_ack !== 1'b0) begin fails++; $display("FAIL b2b_idle_ack: got %b expected 0", data_ack); end
        tests++; if (data_read_data !== vb) begin fails++; $display("FAIL b2b_hold: got %h expected %h", data_read_data, vb); end
        data_req = 1'b1; data_we = 1'b0; data_address = 4'd1;
        tick();
        data_req = 1'b0;
        tests++; if (data_read_data !== va) begin fails++; $display("FAIL b2b_rd1: got %h expected %h", data_read_data, va); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] old;
        old = mdl_mem[7];
        inst_read_address = 4'd7;
        data_req = 1'b1; data_we = 1'b1; data_address = 4'd7; data_write_data = 32'h1234_5678;
        #1;
        tests++; if (inst_read_data !== old) begin fails++; $display("FAIL coll_old: got %h expected %h", inst_read_data, old); end
        tick();
        data_we = 1'b0;
        tests++; if (inst_read_data !== 32'h1234_5678) begin fails++; $display("FAIL coll_new: got %h expected 12345678", inst_read_data); end
        tick();
        data_req = 1'b0;
        tests++; if (data_read_data !== 32'h1234_5678) begin fails++; $display("FAIL raw_read: got %h expected 12345678", data_read_data); end
    endtask

    task automatic test_random_traffic();
        for (int n = 0; n < 300; n++) begin
            data_req          = ($urandom_range(0, 3) != 0);
            data_we           = $urandom_range(0, 1) == 1;
            data_address      = AW'($urandom_range(0, DEPTH - 1));
            data_write_data   = $urandom();
            inst_read_address = AW'($urandom_range(0, DEPTH - 1));
            #1;
            tests++;
            if (inst_read_data !== mdl_mem[inst_read_address]) begin
                fails++; $display("FAIL rnd_inst n%0d: got %h expected %h", n, inst_read_data, mdl_mem[inst_read_address]);
            end
            tick();
            tests++;
            if (data_ack !== exp_ack || data_read_data !== exp_rdata) begin
                fails++; $display("FAIL rnd_data n%0d: got ack=%b rd=%h expected ack=%b rd=%h", n, data_ack, data_read_data, exp_ack, exp_rdata);
            end
        end
        data_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        data_req = 1'b1; data_we = 1'b1; data_address = 4'd2; data_write_data = 32'hA5A5_0002;
        tick();
        data_we = 1'b0; reset = 1'b1;
        tick();
        tests++; if (data_ack !== 1'b0) begin fails++; $display("FAIL mid_ack: got %b expected 0", data_ack); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL mid_ready: got %b expected 0", ready); end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; data_req = 1'b0;
        inst_read_address = 4'd2;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            tests++; if (inst_read_data !== NOP) begin fails++; $display("FAIL reclear_inst c%0d: got %h expected %h", i, inst_read_data, NOP); end
            tick();
            tests++; if (ready !== (i == DEPTH - 1)) begin fails++; $display("FAIL reclear_ready c%0d: got %b expected %b", i, ready, i == DEPTH - 1); end
        end
        #1;
        tests++; if (inst_read_data !== NOP) begin fails++; $display("FAIL reclear_addr2: got %h expected %h", inst_read_data, NOP); end
        tests++; if (data_read_data !== '0) begin fails++; $display("FAIL reclear_rdata: got %h expected 0", data_read_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; data_req = 1'b0; data_we = 1'b0;
        data_address = '0; data_write_data = '0; inst_read_address = '0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = NOP;
        test_reset();
        test_clear_with_held_req();
        test_write_then_fetch();
        test_back_to_back();
        test_collision();
        test_random_traffic();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
